// File: rtl/checkout_unit.sv
// =============================================================================
// Module      : checkout_unit
// Description : Prices a sampled cart total (optional volume discount, sales
//               tax), collects payment tokens, then issues change or a refund.
//               Discount logic is built only when CHECKOUT_DISCOUNT_EN is defined.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module checkout_unit #(
    parameter int unsigned TAX_PERMILLE   = 80,
    parameter int unsigned DISC_THRESHOLD = 1000,
    parameter int unsigned DISC_PERMILLE  = 100
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic [31:0] cart_total_i,
    input  logic        checkout_start_i,
    input  logic        cancel_i,
    input  logic        pay_valid_i,
    input  logic [15:0] pay_amount_i,
    output logic        pay_ready_o,
    output logic        busy_o,
    output logic [31:0] amount_due_o,
    output logic [31:0] paid_total_o,
    output logic        change_valid_o,
    output logic [31:0] change_amount_o,
    output logic        refund_valid_o,
    output logic [31:0] refund_amount_o,
    output logic        done_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRICE   = 3'd1,
        S_COLLECT = 3'd2,
        S_CHANGE  = 3'd3,
        S_REFUND  = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] base_q, base_d;
    logic [31:0] amount_due_q, amount_due_d;
    logic [31:0] paid_total_q, paid_total_d;

    // All pricing arithmetic is kept 42 bits wide: a 32-bit value times a
    // per-mille rate of at most 1000 cannot exceed 2^42.
    logic [41:0] w_base42;
    logic [41:0] w_disc42;
    logic [41:0] w_net42;
    logic [41:0] w_tax42;
    logic [41:0] w_sum42;
    logic [31:0] w_price;

    assign w_base42 = {10'd0, base_q};

`ifdef CHECKOUT_DISCOUNT_EN
    assign w_disc42 = (base_q >= DISC_THRESHOLD)
                    ? (w_base42 * 42'(DISC_PERMILLE)) / 42'd1000
                    : 42'd0;
`else
    logic w_unused_disc_cfg;
    assign w_unused_disc_cfg = (DISC_THRESHOLD != 0) ^ (DISC_PERMILLE != 0);
    assign w_disc42 = 42'd0;
`endif

    assign w_net42 = w_base42 - w_disc42;
    assign w_tax42 = (w_net42 * 42'(TAX_PERMILLE)) / 42'd1000;
    assign w_sum42 = w_net42 + w_tax42;
    assign w_price = (|w_sum42[41:32]) ? 32'hFFFF_FFFF : w_sum42[31:0];

    logic        w_accept;
    logic [32:0] w_paid_sum;
    logic [31:0] w_paid_next;

    assign pay_ready_o = (state_q == S_COLLECT) && !cancel_i;
    assign w_accept    = pay_valid_i && pay_ready_o;
    assign w_paid_sum  = {1'b0, paid_total_q} + {17'd0, pay_amount_i};
    assign w_paid_next = w_paid_sum[32] ? 32'hFFFF_FFFF : w_paid_sum[31:0];

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            amount_due_q <= '0;
            paid_total_q <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            amount_due_q <= amount_due_d;
            paid_total_q <= paid_total_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        amount_due_d = amount_due_q;
        paid_total_d = paid_total_q;

        unique case (state_q)
            S_IDLE: begin
                if (checkout_start_i) begin
                    base_d       = cart_total_i;
                    paid_total_d = '0;
                    state_d      = S_PRICE;
                end
            end
            S_PRICE: begin
                amount_due_d = w_price;
                state_d      = (w_price == 32'd0) ? S_CHANGE : S_COLLECT;
            end
            S_COLLECT: begin
                // cancel also drops pay_ready, so no token is taken with it
                if (cancel_i) begin
                    state_d = S_REFUND;
                end else if (w_accept) begin
                    paid_total_d = w_paid_next;
                    if (w_paid_next >= amount_due_q) begin
                        state_d = S_CHANGE;
                    end
                end
            end
            S_CHANGE: state_d = S_DONE;
            S_REFUND: state_d = S_IDLE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign busy_o          = (state_q != S_IDLE);
    assign amount_due_o    = amount_due_q;
    assign paid_total_o    = paid_total_q;
    assign change_valid_o  = (state_q == S_CHANGE);
    assign change_amount_o = (state_q == S_CHANGE) ? (paid_total_q - amount_due_q) : 32'd0;
    assign refund_valid_o  = (state_q == S_REFUND);
    assign refund_amount_o = (state_q == S_REFUND) ? paid_total_q : 32'd0;
    assign done_o          = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_checkout_unit.sv
// =============================================================================
// Module      : tb_checkout_unit
// Description : Directed self-checking bench for checkout_unit.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_checkout_unit;

`ifdef CHECKOUT_DISCOUNT_EN
    localparam logic [31:0] C_EXP_2000 = 32'd1944;
    localparam logic [31:0] C_EXP_1000 = 32'd972;
    localparam logic [31:0] C_EXP_MAX  = 32'd4174708211;
`else
    localparam logic [31:0] C_EXP_2000 = 32'd2160;
    localparam logic [31:0] C_EXP_1000 = 32'd1080;
    localparam logic [31:0] C_EXP_MAX  = 32'hFFFF_FFFF;
`endif

    logic        clk;
    logic        reset_n;
    logic [31:0] cart_total;
    logic        checkout_start;
    logic        cancel;
    logic        pay_valid;
    logic [15:0] pay_amount;
    logic        pay_ready;
    logic        busy;
    logic [31:0] amount_due;
    logic [31:0] paid_total;
    logic        change_valid;
    logic [31:0] change_amount;
    logic        refund_valid;
    logic [31:0] refund_amount;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    checkout_unit dut (
        .clk_i            (clk),
        .reset_ni         (reset_n),
        .cart_total_i     (cart_total),
        .checkout_start_i (checkout_start),
        .cancel_i         (cancel),
        .pay_valid_i      (pay_valid),
        .pay_amount_i     (pay_amount),
        .pay_ready_o      (pay_ready),
        .busy_o           (busy),
        .amount_due_o     (amount_due),
        .paid_total_o     (paid_total),
        .change_valid_o   (change_valid),
        .change_amount_o  (change_amount),
        .refund_valid_o   (refund_valid),
        .refund_amount_o  (refund_amount),
        .done_o           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%08h) expected %0d (0x%08h)", tag, obs, obs, exp, exp);
        end
    endtask

    // advance one rising edge; stimulus and sampling both happen 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n        = 1'b0;
        cart_total     = '0;
        checkout_start = 1'b0;
        cancel         = 1'b0;
        pay_valid      = 1'b0;
        pay_amount     = '0;
        #2;
        chk("rst_busy",       32'(busy), 32'd0);
        chk("rst_pay_ready",  32'(pay_ready), 32'd0);
        chk("rst_amount_due", amount_due, 32'd0);
        chk("rst_paid_total", paid_total, 32'd0);
        chk("rst_pulses",     32'({change_valid, refund_valid, done}), 32'd0);
        step();
        step();
        reset_n = 1'b1;
        step();
        chk("idle_busy", 32'(busy), 32'd0);

        // 350: below threshold, 378 due; 200 + 200 overpays by 22
        cart_total     = 32'd350;
        checkout_start = 1'b1;
        step();
        checkout_start = 1'b0;
        chk("t1_price_busy",  32'(busy), 32'd1);
        chk("t1_price_ready", 32'(pay_ready), 32'd0);
        step();
        chk("t1_due",   amount_due, 32'd378);
        chk("t1_ready", 32'(pay_ready), 32'd1);
        pay_valid  = 1'b1;
        pay_amount = 16'd200;
        step();
        chk("t1_paid1", paid_total, 32'd200);
        chk("t1_no_change_yet", 32'(change_valid), 32'd0);
        step();
        pay_valid = 1'b0;
        chk("t1_paid2",      paid_total, 32'd400);
        chk("t1_change_vld", 32'(change_valid), 32'd1);
        chk("t1_change_amt", change_amount, 32'd22);
        chk("t1_done_early", 32'(done), 32'd0);
        step();
        chk("t1_done",       32'(done), 32'd1);
        chk("t1_change_off", 32'(change_valid), 32'd0);
        chk("t1_busy_done",  32'(busy), 32'd1);
        step();
        chk("t1_done_off", 32'(done), 32'd0);
        chk("t1_idle",     32'(busy), 32'd0);

        // 2000: discount boundary case, then cancel with nothing paid
        cart_total     = 32'd2000;
        checkout_start = 1'b1;
        step();
        checkout_start = 1'b0;
        step();
        chk("t2_due", amount_due, C_EXP_2000);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("t2_refund_vld", 32'(refund_valid), 32'd1);
        chk("t2_refund_amt", refund_amount, 32'd0);
        step();
        chk("t2_idle", 32'(busy), 32'd0);

        // zero total: straight from PRICE to CHANGE, offered tokens ignored
        cart_total     = 32'd0;
        checkout_start = 1'b1;
        pay_valid      = 1'b1;
        pay_amount     = 16'd77;
        step();
        checkout_start = 1'b0;
        step();
        chk("t3_change_vld", 32'(change_valid), 32'd1);
        chk("t3_change_amt", change_amount, 32'd0);
        chk("t3_due",        amount_due, 32'd0);
        chk("t3_paid",       paid_total, 32'd0);
        step();
        pay_valid = 1'b0;
        chk("t3_done", 32'(done), 32'd1);
        step();
        chk("t3_idle", 32'(busy), 32'd0);

        // threshold exactly met; cancel wins over a simultaneous token
        cart_total     = 32'd1000;
        checkout_start = 1'b1;
        step();
        checkout_start = 1'b0;
        step();
        chk("t4_due", amount_due, C_EXP_1000);
        pay_valid  = 1'b1;
        pay_amount = 16'd300;
        step();
        chk("t4_paid", paid_total, 32'd300);
        pay_amount = 16'd500;
        cancel     = 1'b1;
        #1;
        chk("t4_ready_cancel", 32'(pay_ready), 32'd0);
        step();
        cancel    = 1'b0;
        pay_valid = 1'b0;
        chk("t4_refund_vld", 32'(refund_valid), 32'd1);
        chk("t4_refund_amt", refund_amount, 32'd300);
        chk("t4_paid_kept",  paid_total, 32'd300);
        chk("t4_no_done",    32'(done), 32'd0);
        step();
        chk("t4_idle",      32'(busy), 32'd0);
        chk("t4_no_done2",  32'(done), 32'd0);
        chk("t4_refund_off", 32'(refund_valid), 32'd0);

        // maximum cart total: saturates unless the discount pulls it back in range
        cart_total     = 32'hFFFF_FFFF;
        checkout_start = 1'b1;
        step();
        checkout_start = 1'b0;
        step();
        chk("t5_due_max", amount_due, C_EXP_MAX);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        step();

        // reset in the middle of collection, then a fresh 100 -> 108 checkout
        cart_total     = 32'd500;
        checkout_start = 1'b1;
        step();
        checkout_start = 1'b0;
        step();
        pay_valid  = 1'b1;
        pay_amount = 16'd150;
        step();
        pay_valid = 1'b0;
        chk("t6_paid_pre", paid_total, 32'd150);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_busy",  32'(busy), 32'd0);
        chk("t6_rst_paid",  paid_total, 32'd0);
        chk("t6_rst_due",   amount_due, 32'd0);
        chk("t6_rst_ready", 32'(pay_ready), 32'd0);
        step();
        chk("t6_rst_pulses", 32'({change_valid, refund_valid, done}), 32'd0);
        reset_n = 1'b1;
        step();
        cart_total     = 32'd100;
        checkout_start = 1'b1;
        step();
        step();
        chk("t6_due", amount_due, 32'd108);
        // start still held: after a cancel the next checkout re-arms at once
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("t7_refund", 32'(refund_valid), 32'd1);
        cart_total = 32'd200;
        step();
        chk("t7_idle_once", 32'(busy), 32'd0);
        step();
        checkout_start = 1'b0;
        chk("t7_rearm_busy", 32'(busy), 32'd1);
        step();
        chk("t7_due", amount_due, 32'd216);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/checkout_unit.md
# checkout_unit

Downstream stage of the cart: on a checkout request, samples the cart's running 32-bit total, applies an optional volume discount and a fixed sales tax to form the amount due, then collects payment tokens over a valid/ready handshake. It issues change when the payment covers the amount due, or a full refund if the customer cancels first. One checkout is in flight at a time; the block idles between checkouts.

## Interface
- TAX_PERMILLE, 80, tax rate in 1/1000 units (80 = 8.0%); range 0–1000
- DISC_THRESHOLD, 1000, minimum cart total at which the discount applies
- DISC_PERMILLE, 100, discount rate in 1/1000 units; range 0–1000
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- cart_total  in  32  cart total from the cart stage; sampled only on accepted checkout_start
- checkout_start  in  1  request a checkout; accepted only in IDLE
- cancel  in  1  abort the checkout; honoured only in COLLECT
- pay_valid  in  1  payment token present
- pay_amount  in  16  value of the payment token
- pay_ready  out  1  combinational: (state == COLLECT) && !cancel
- busy  out  1  high in every state except IDLE
- amount_due  out  32  registered amount due for the current checkout
- paid_total  out  32  registered running sum of accepted payments
- change_valid  out  1  one-cycle pulse; change_amount is valid
- change_amount  out  32  paid_total − amount_due
- refund_valid  out  1  one-cycle pulse; refund_amount is valid
- refund_amount  out  32  paid_total at the time of the cancel
- done  out  1  one-cycle pulse at the end of a successful checkout

## Operation
- States: IDLE, PRICE, COLLECT, CHANGE, REFUND, DONE.
- IDLE:
  - When checkout_start = 1: latch cart_total into base, clear paid_total, go to PRICE.
  - Otherwise stay.
- PRICE: one cycle. Compute and register amount_due:
  - disc = (base ≥ DISC_THRESHOLD) ? base·DISC_PERMILLE/1000 : 0
  - net = base − disc
  - amount_due = net + net·TAX_PERMILLE/1000
  - Both divisions truncate toward zero. Products use 42-bit intermediates.
  - If the final sum exceeds 2^32−1, saturate amount_due to 0xFFFF_FFFF.
  - If amount_due = 0, go to CHANGE; otherwise go to COLLECT.
- COLLECT:
  - A payment is accepted on each cycle where pay_valid && pay_ready.
  - On acceptance, paid_total += zero-extended pay_amount, saturating at 0xFFFF_FFFF.
  - If the updated paid_total ≥ amount_due, go to CHANGE.
  - If cancel = 1, go to REFUND. Cancel has priority: the token offered in that same cycle is not accepted.
- CHANGE: change_valid = 1 and change_amount = paid_total − amount_due, for one cycle. Go to DONE.
- REFUND: refund_valid = 1 and refund_amount = paid_total, for one cycle (the value may be 0). Go to IDLE. done is not asserted.
- DONE: done = 1 for one cycle. Go to IDLE.
- Ignored inputs:
  - checkout_start outside IDLE.
  - cancel outside COLLECT.
  - pay_valid outside COLLECT (pay_ready = 0).
- Overpayment: the excess from the final token is returned entirely through change_amount. Later tokens are not accepted.

## Timing
- Reset (asynchronous, reset = 0): state = IDLE and every registered output = 0. busy, change_valid, refund_valid and done are all 0. pay_ready = 0.
- Checkout accepted at edge N → PRICE during cycle N+1 → COLLECT (pay_ready = 1) from cycle N+2.
- amount_due is stable from cycle N+2 until the next accepted checkout.
- A token accepted at edge M updates paid_total at M+1.
  - If that token covers the amount due, change_valid is high in cycle M+1 and done is high in M+2.
  - busy falls in cycle M+3.
- cancel sampled at edge K → refund_valid high in cycle K+1 → IDLE in K+2.
- Back-to-back checkouts: a checkout_start held high re-arms on the first IDLE cycle after done or refund.
- Reset asserted mid-checkout: the transaction is abandoned immediately. No change, refund or done pulse is produced.

## Configuration
- CHECKOUT_DISCOUNT_EN defined: the discount term is computed as described above.
- CHECKOUT_DISCOUNT_EN undefined:
  - disc is hard-wired to 0 and the discount logic is not synthesised.
  - DISC_THRESHOLD and DISC_PERMILLE are accepted but have no effect.
  - All timing is unchanged; PRICE is still one cycle.

## Test plan
- Defaults, macro defined; cart_total = 350; start; tokens 200, 200 → amount_due = 378; change_valid with change_amount = 22; done one cycle later.
- cart_total = 2000 → amount_due = 1944 (disc 200, tax 144). Rebuild without CHECKOUT_DISCOUNT_EN → amount_due = 2160.
- cart_total = 0; start → no payment accepted; change_valid with 0 in the cycle after PRICE; then done.
- cart_total = 1000; pay 300; then cancel together with pay_valid = 1 (amount 500) → token rejected; refund_valid with refund_amount = 300; done never asserted.
- cart_total = 0xFFFF_FFFF, TAX_PERMILLE = 80, macro undefined → amount_due saturates to 0xFFFF_FFFF.
- Reset pulled low during COLLECT with paid_total = 150 → all outputs 0 immediately; after reset release, a new start with cart_total = 100 gives amount_due = 108.
